// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty meter and the circle PWM generators.
package pwm_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int PWM_FRAME = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        MEAS  = 2'd2,
        STUCK = 2'd3
    } meter_state_t;

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Pin-side inputs and measurement results of the duty meter.
// The master side drives the PWM line and enable; the slave side is the meter.
interface pwm_duty_meter_if #(
    parameter int CNT_W = pwm_pkg::DEF_CNT_W
);
    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] period;
    logic             sample_valid;
    logic             stuck_high;
    logic             stuck_low;

    modport master (
        output enable, pwm_in,
        input  duty, period, sample_valid, stuck_high, stuck_low
    );

    modport slave (
        input  enable, pwm_in,
        output duty, period, sample_valid, stuck_high, stuck_low
    );
endinterface

// File: rtl/pwm_duty_meter_sync_edge.sv
// Purpose: synchronise an asynchronous line and detect its rising edge.
// Latency: level valid SYNC_STAGES cycles after capture; rise in the same cycle as level.
// Backpressure: none, free-running every cycle.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;

endmodule

// File: rtl/pwm_duty_meter.sv
// Purpose: measure high-time and period of each PWM frame, flag stuck-high/low lines.
// Latency: sample_valid one cycle after the synchronised rise (pin edge + SYNC_STAGES + 1).
// Backpressure: none; sample_valid is a one-cycle strobe the consumer must capture.
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             sysclk,
    input  logic             rst_n,
    pwm_duty_meter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

    meter_state_t     state, state_nxt;
    logic [CNT_W-1:0] hi_cnt, hi_nxt;
    logic [CNT_W-1:0] per_cnt, per_nxt;
    logic [CNT_W-1:0] duty_q, duty_nxt;
    logic [CNT_W-1:0] period_q, period_nxt;
    logic             sv_q, sv_nxt;
    logic             sh_q, sh_nxt;
    logic             sl_q, sl_nxt;
    logic             pwm_s;
    logic             rise;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .async_in (bus.pwm_in),
        .level    (pwm_s),
        .rise     (rise)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hi_cnt   <= '0;
            per_cnt  <= '0;
            duty_q   <= '0;
            period_q <= '0;
            sv_q     <= 1'b0;
            sh_q     <= 1'b0;
            sl_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hi_cnt   <= hi_nxt;
            per_cnt  <= per_nxt;
            duty_q   <= duty_nxt;
            period_q <= period_nxt;
            sv_q     <= sv_nxt;
            sh_q     <= sh_nxt;
            sl_q     <= sl_nxt;
        end
    end

    // per_cnt doubles as the ARM timeout timer; the edge after any stuck interval only opens a frame.
    always_comb begin
        state_nxt  = state;
        hi_nxt     = hi_cnt;
        per_nxt    = per_cnt;
        duty_nxt   = duty_q;
        period_nxt = period_q;
        sv_nxt     = 1'b0;
        sh_nxt     = sh_q;
        sl_nxt     = sl_q;

        if (!bus.enable) begin
            state_nxt = IDLE;
            hi_nxt    = '0;
            per_nxt   = '0;
            sh_nxt    = 1'b0;
            sl_nxt    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = ARM;
                    hi_nxt    = '0;
                    per_nxt   = CNT_ONE;
                end
                ARM: begin
                    if (rise) begin
                        state_nxt = MEAS;
                        hi_nxt    = CNT_ONE;
                        per_nxt   = CNT_ONE;
                    end else if (per_cnt >= TO_CNT) begin
                        state_nxt = STUCK;
                        sh_nxt    = pwm_s;
                        sl_nxt    = ~pwm_s;
                    end else begin
                        per_nxt   = sat_inc(per_cnt);
                    end
                end
                MEAS: begin
                    if (rise) begin
                        duty_nxt   = hi_cnt;
                        period_nxt = per_cnt;
                        sv_nxt     = 1'b1;
                        hi_nxt     = CNT_ONE;
                        per_nxt    = CNT_ONE;
                    end else if (per_cnt >= TO_CNT) begin
                        state_nxt  = STUCK;
                        sh_nxt     = pwm_s;
                        sl_nxt     = ~pwm_s;
                    end else begin
                        per_nxt    = sat_inc(per_cnt);
                        if (pwm_s) begin
                            hi_nxt = sat_inc(hi_cnt);
                        end
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state_nxt = MEAS;
                        sh_nxt    = 1'b0;
                        sl_nxt    = 1'b0;
                        hi_nxt    = CNT_ONE;
                        per_nxt   = CNT_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.duty         = duty_q;
    assign bus.period       = period_q;
    assign bus.sample_valid = sv_q;
    assign bus.stuck_high   = sh_q;
    assign bus.stuck_low    = sl_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomised PWM stimulus on the duty meter, checked every cycle against a timestamp-based reference.
module tb_pwm_duty_meter;
    import pwm_pkg::*;

    localparam int TIMEOUT = 255;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;

    pwm_duty_meter_if bus ();

    pwm_duty_meter #(
        .CNT_W       (8),
        .SYNC_STAGES (2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int checks  = 0;
    int errors  = 0;
    int sv_seen = 0;

    // Reference: pin level seen by the meter at edge m is the pin value captured at edge m-2.
    // Duty and period come from timestamps of the frame-opening rise and a running count of high cycles.
    bit       l1 = 0, l2 = 0, l3 = 0;
    bit       active = 0, meas = 0, m_stuck = 0;
    int       cyc = 0, t0 = 0, ones = 0, ones_t0 = 0;
    logic [7:0] exp_duty = '0, exp_period = '0;
    logic     exp_sv = 0, exp_sh = 0, exp_sl = 0;

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            l1 = 0; l2 = 0; l3 = 0;
            active = 0; meas = 0; m_stuck = 0;
            exp_duty = '0; exp_period = '0;
            exp_sv = 0; exp_sh = 0; exp_sl = 0;
        end else begin
            bit s, r;
            int d, p;
            s = l2;
            r = l2 && !l3;
            exp_sv = 0;
            if (!bus.enable) begin
                active = 0; meas = 0; m_stuck = 0;
                exp_sh = 0; exp_sl = 0;
            end else if (!active) begin
                active = 1; meas = 0; t0 = cyc;
            end else if (r) begin
                if (meas && !m_stuck) begin
                    p = cyc - t0;
                    d = ones - ones_t0;
                    exp_sv     = 1;
                    exp_period = (p > 255) ? 8'd255 : 8'(p);
                    exp_duty   = (d > 255) ? 8'd255 : 8'(d);
                end
                meas = 1; m_stuck = 0; exp_sh = 0; exp_sl = 0;
                t0 = cyc; ones_t0 = ones;
            end else if (!m_stuck && (cyc - t0) >= TIMEOUT) begin
                m_stuck = 1; exp_sh = s; exp_sl = !s;
            end
            ones = ones + int'(s);
            cyc  = cyc + 1;
            l3 = l2; l2 = l1; l1 = bus.pwm_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        chk("duty",         32'(bus.duty),         32'(exp_duty));
        chk("period",       32'(bus.period),       32'(exp_period));
        chk("sample_valid", 32'(bus.sample_valid), 32'(exp_sv));
        chk("stuck_high",   32'(bus.stuck_high),   32'(exp_sh));
        chk("stuck_low",    32'(bus.stuck_low),    32'(exp_sl));
        if (bus.sample_valid === 1'b1) sv_seen++;
    endtask

    task automatic cyc_drive(input bit p);
        @(negedge sysclk);
        check_all();
        bus.pwm_in = p;
    endtask

    task automatic frames(input int per, input int hi, input int n);
        for (int f = 0; f < n; f++)
            for (int k = 0; k < per; k++)
                cyc_drive(k < hi);
    endtask

    initial begin
        int per, hi;
        bus.enable = 1'b0;
        bus.pwm_in = 1'b0;

        // reset state
        repeat (3) cyc_drive(0);
        chk("rst_duty",   32'(bus.duty),   0);
        chk("rst_period", 32'(bus.period), 0);
        rst_n = 1'b1;
        cyc_drive(0);

        // 64-cycle frame, 33 high: three samples from four frame starts
        bus.enable = 1'b1;
        sv_seen = 0;
        frames(PWM_FRAME, 33, 4);
        chk("sv_count_4frames", 32'(sv_seen), 3);
        chk("duty_33",   32'(bus.duty),   33);
        chk("period_64", 32'(bus.period), 64);

        // 63/64 duty, checked once the next frame's rise has landed
        frames(PWM_FRAME, 63, 1);
        repeat (4) cyc_drive(1);
        chk("duty_63",     32'(bus.duty),   63);
        chk("period_63f",  32'(bus.period), 64);
        for (int k = 4; k < PWM_FRAME; k++) cyc_drive(k < 30);

        // random LUT-like duty sweep at fixed frame
        for (int i = 0; i < 12; i++) frames(PWM_FRAME, $urandom_range(1, 63), 1);

        // random period and duty
        for (int i = 0; i < 10; i++) begin
            per = $urandom_range(2, 120);
            hi  = $urandom_range(1, per - 1);
            frames(per, hi, 1);
        end

        // stuck low, then recovery
        repeat (300) cyc_drive(0);
        chk("stuck_low_set", 32'(bus.stuck_low), 1);
        frames(50, 20, 3);

        // stuck high, then recovery
        repeat (300) cyc_drive(1);
        chk("stuck_high_set", 32'(bus.stuck_high), 1);
        repeat (5) cyc_drive(0);
        frames(50, 20, 3);

        // enable dropped mid-frame for 10 cycles
        frames(PWM_FRAME, 33, 3);
        for (int k = 0; k < 20; k++) cyc_drive(k < 33);
        bus.enable = 1'b0;
        sv_seen = 0;
        for (int k = 20; k < 30; k++) cyc_drive(k < 33);
        chk("sv_while_disabled", 32'(sv_seen), 0);
        chk("duty_held",   32'(bus.duty),   33);
        chk("period_held", 32'(bus.period), 64);
        bus.enable = 1'b1;
        for (int k = 30; k < PWM_FRAME; k++) cyc_drive(k < 33);
        frames(PWM_FRAME, 33, 3);

        // async reset mid-frame, off the clock edge
        for (int k = 0; k < 20; k++) cyc_drive(k < 33);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_duty",   32'(bus.duty),   0);
        chk("arst_period", 32'(bus.period), 0);
        check_all();
        for (int k = 20; k < 24; k++) cyc_drive(k < 33);
        rst_n = 1'b1;
        for (int k = 24; k < PWM_FRAME; k++) cyc_drive(k < 33);
        frames(PWM_FRAME, 33, 3);

        // single-cycle glitches as frames
        frames(20, 1, 6);
        frames(PWM_FRAME, 10, 2);

        // ARM timeout with the line idle low after re-enable
        bus.enable = 1'b0;
        repeat (3) cyc_drive(0);
        bus.enable = 1'b1;
        repeat (270) cyc_drive(0);
        chk("arm_stuck_low", 32'(bus.stuck_low), 1);
        frames(40, 15, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
